// File: rtl/branch_off_pack.sv
// ============================================================================
//  Module   : branch_off_pack
//  Purpose  : Packs a 32-bit branch target into a 16-bit word-offset immediate
//             (inverse of the sign-extend-and-shift-by-2 branch extender).
//             Two-stage valid/ready pipeline with misalign and range flags.
//  Options  : define BRANCH_OFF_PACK_STATS_EN to add the oErrCnt error counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_off_pack #(
    parameter logic [31:0] PC_OFFSET = 32'd4
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iValid,
    output logic        oReady,
    input  logic [31:0] iPC,
    input  logic [31:0] iTarget,
    output logic        oValid,
    input  logic        iReady,
    output logic [15:0] oImm16,
    output logic        oMisalign,
    output logic        oRange
`ifdef BRANCH_OFF_PACK_STATS_EN
    ,
    output logic [15:0] oErrCnt
`endif
);

    logic        r_s1Valid;
    logic [31:0] r_s1Diff;
    logic        r_s2Valid;
    logic [15:0] r_s2Imm;
    logic        r_s2Misalign;
    logic        r_s2Range;

    logic        w_s2Load;
    logic        w_s1Load;
    logic [31:0] w_diff;
    logic        w_misalign;
    logic        w_range;

    // S2 takes S1's entry when it is empty or its own result leaves this cycle.
    assign w_s2Load = r_s1Valid && (!r_s2Valid || iReady);
    assign oReady   = !r_s1Valid || w_s2Load;
    assign w_s1Load = iValid && oReady;

    assign w_diff     = iTarget - (iPC + PC_OFFSET);
    assign w_misalign = (r_s1Diff[1:0] != 2'b00);
    assign w_range    = (r_s1Diff[31:17] != {15{r_s1Diff[17]}});

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Diff  <= 32'd0;
        end else begin
            if (oReady) begin
                r_s1Valid <= iValid;
            end
            if (w_s1Load) begin
                r_s1Diff <= w_diff;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_s2Valid    <= 1'b0;
            r_s2Imm      <= 16'h0000;
            r_s2Misalign <= 1'b0;
            r_s2Range    <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid    <= 1'b1;
            r_s2Misalign <= w_misalign;
            r_s2Range    <= w_range;
            r_s2Imm      <= (w_misalign || w_range) ? 16'h0000 : r_s1Diff[17:2];
        end else if (iReady) begin
            r_s2Valid <= 1'b0;
        end
    end

    assign oValid    = r_s2Valid;
    assign oImm16    = r_s2Imm;
    assign oMisalign = r_s2Misalign;
    assign oRange    = r_s2Range;

`ifdef BRANCH_OFF_PACK_STATS_EN
    logic [15:0] r_errCnt;
    logic        w_errXfer;

    assign w_errXfer = r_s2Valid && iReady && (r_s2Misalign || r_s2Range);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_errCnt <= 16'h0000;
        end else if (w_errXfer && (r_errCnt != 16'hFFFF)) begin
            r_errCnt <= r_errCnt + 16'd1;
        end
    end

    assign oErrCnt = r_errCnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_off_pack.sv
// ============================================================================
//  Module   : tb_branch_off_pack
//  Purpose  : Self-checking bench for branch_off_pack: directed vector table,
//             stall/reset sequences and randomized traffic vs. a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_off_pack;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [15:0] imm;
        logic        mis;
        logic        rng;
    } vec_t;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iValid;
    logic        oReady;
    logic [31:0] iPC;
    logic [31:0] iTarget;
    logic        oValid;
    logic        iReady;
    logic [15:0] oImm16;
    logic        oMisalign;
    logic        oRange;
`ifdef BRANCH_OFF_PACK_STATS_EN
    logic [15:0] oErrCnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [17:0] sb[$];
    logic        prevStall = 1'b0;
    logic [17:0] held;

    always #5 iClk = ~iClk;

    branch_off_pack #(.PC_OFFSET(32'd4)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iValid    (iValid),
        .oReady    (oReady),
        .iPC       (iPC),
        .iTarget   (iTarget),
        .oValid    (oValid),
        .iReady    (iReady),
        .oImm16    (oImm16),
        .oMisalign (oMisalign),
        .oRange    (oRange)
`ifdef BRANCH_OFF_PACK_STATS_EN
        ,
        .oErrCnt   (oErrCnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Signed word offset by plain arithmetic; flags from whether it fits in 16 bits.
    function automatic logic [17:0] refModel(input logic [31:0] pc, input logic [31:0] tgt);
        logic [31:0] d;
        longint      w;
        logic        m;
        logic        r;
        logic [15:0] imm;
        d   = tgt - pc - 32'd4;
        m   = (d % 32'd4) != 32'd0;
        w   = longint'($signed(d)) >>> 2;
        r   = (w < -32768) || (w > 32767);
        imm = (m || r) ? 16'h0000 : w[15:0];
        return {imm, m, r};
    endfunction

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic rdy, output logic acc);
        int n;
        logic [17:0] exp;
        @(negedge iClk);
        iValid  = v;
        iPC     = pc;
        iTarget = tgt;
        iReady  = rdy;
        #1;
        n = sb.size();
        if (prevStall) begin
            chk("stall_valid", {31'd0, oValid}, 32'd1);
            chk("stall_hold", {14'd0, oImm16, oMisalign, oRange}, {14'd0, held});
        end
        chk("ready", {31'd0, oReady}, {31'd0, !(n == 2 && !rdy)});
        if (n == 0) chk("valid_empty", {31'd0, oValid}, 32'd0);
        if (n == 2) chk("valid_full", {31'd0, oValid}, 32'd1);
        acc = v && oReady;
        if (oValid && rdy) begin
            if (n == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                chk("result", {14'd0, oImm16, oMisalign, oRange}, {14'd0, exp});
            end
        end
        if (acc) sb.push_back(refModel(pc, tgt));
        prevStall = oValid && !rdy;
        held      = {oImm16, oMisalign, oRange};
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        chk("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic applyReset();
        @(negedge iClk);
        iRst_n = 1'b0;
        iValid = 1'b1;
        @(negedge iClk);
        #1;
        sb.delete();
        prevStall = 1'b0;
        chk("rst_valid", {31'd0, oValid}, 32'd0);
        chk("rst_ready", {31'd0, oReady}, 32'd1);
        chk("rst_outs", {14'd0, oImm16, oMisalign, oRange}, 32'd0);
        iRst_n = 1'b1;
        iValid = 1'b0;
    endtask

    initial begin
        vec_t        tbl[10];
        logic        acc;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] off;
        logic [31:0] edges[4];
        int          idx;

        tbl[0] = '{32'h0040_0000, 32'h0040_0010, 16'h0003, 1'b0, 1'b0};
        tbl[1] = '{32'h0040_0100, 32'h0040_0000, 16'hFFBF, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_1000, 32'h0002_1004, 16'h0000, 1'b0, 1'b1};
        tbl[3] = '{32'h0000_1000, 32'h0002_1000, 16'h7FFF, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_1000, 32'h0000_1006, 16'h0000, 1'b1, 1'b0};
        tbl[5] = '{32'hFFFF_FFFC, 32'h0000_0010, 16'h0004, 1'b0, 1'b0};
        tbl[6] = '{32'hFFFF_FFF8, 32'h0000_0000, 16'h0001, 1'b0, 1'b0};
        tbl[7] = '{32'h0001_0000, 32'hFFFF_0004, 16'h8000, 1'b0, 1'b0};
        tbl[8] = '{32'h0001_0000, 32'hFFFF_0000, 16'h0000, 1'b0, 1'b1};
        tbl[9] = '{32'h0000_0000, 32'h0010_0005, 16'h0000, 1'b1, 1'b1};
        edges[0] = 32'h0001_FFFC;
        edges[1] = 32'h0002_0000;
        edges[2] = 32'hFFFE_0000;
        edges[3] = 32'hFFFD_FFFC;

        iRst_n = 1'b0; iValid = 1'b0; iReady = 1'b0; iPC = '0; iTarget = '0;
        repeat (2) @(negedge iClk);
        #1;
        chk("reset_valid", {31'd0, oValid}, 32'd0);
        chk("reset_ready", {31'd0, oReady}, 32'd1);
        chk("reset_outs", {14'd0, oImm16, oMisalign, oRange}, 32'd0);
        iRst_n = 1'b1;

        // Directed vectors, each checked exactly two edges after acceptance.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].pc, tbl[i].tgt, 1'b1, acc);
            chk("vec_accept", {31'd0, acc}, 32'd1);
            step(1'b0, 32'd0, 32'd0, 1'b1, acc);
            chk("vec_lat1", {31'd0, oValid}, 32'd0);
            step(1'b0, 32'd0, 32'd0, 1'b1, acc);
            chk("vec_lat2", {31'd0, oValid}, 32'd1);
            chk("vec_out", {14'd0, oImm16, oMisalign, oRange},
                {14'd0, tbl[i].imm, tbl[i].mis, tbl[i].rng});
        end

        // Five back-to-back requests while the sink stalls for four cycles.
        idx = 0;
        for (int c = 0; c < 30 && idx < 5; c++) begin
            step(1'b1, 32'h0000_2000 + 32'(idx * 16), 32'h0000_3000 + 32'(idx * 4), (c >= 4), acc);
            if (acc) idx++;
        end
        chk("stream_sent", idx, 32'd5);
        drain();

        // Reset with both stages full discards everything in flight.
        step(1'b1, 32'h100, 32'h200, 1'b0, acc);
        step(1'b1, 32'h100, 32'h204, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, acc);
        applyReset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b1, acc);

`ifdef BRANCH_OFF_PACK_STATS_EN
        chk("errcnt_rst", {16'd0, oErrCnt}, 32'd0);
        step(1'b1, 32'h0, 32'h0000_0006, 1'b1, acc);
        step(1'b1, 32'h0, 32'h0000_0010, 1'b1, acc);
        step(1'b1, 32'h0, 32'h0010_0004, 1'b1, acc);
        step(1'b1, 32'h0, 32'h0010_0005, 1'b1, acc);
        drain();
        step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        chk("errcnt_three", {16'd0, oErrCnt}, 32'd3);
        applyReset();
        #1;
        chk("errcnt_clear", {16'd0, oErrCnt}, 32'd0);
`endif

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            pc = $urandom;
            case ($urandom_range(0, 3))
                0:       off = 32'($signed($urandom_range(0, 65535)) - 32768) << 2;
                1:       off = $urandom;
                2:       off = edges[$urandom_range(0, 3)];
                default: off = 32'($urandom_range(0, 255)) - 32'd128;
            endcase
            tgt = pc + 32'd4 + off;
            step(($urandom_range(0, 9) < 7), pc, tgt, ($urandom_range(0, 9) < 6), acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
